// File: rtl/alu_pkg.sv
// alu_pkg: opcode and FSM encodings shared by the sequential ALU and its bench
package alu_pkg;
    localparam int MODE_W = 4;
    typedef enum logic [MODE_W-1:0] {
        OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBB = 4'd3,
        OP_INC = 4'd4,  OP_DEC = 4'd5,  OP_AND = 4'd6,  OP_OR  = 4'd7,
        OP_XOR = 4'd8,  OP_NOT = 4'd9,  OP_SHL = 4'd10, OP_SHR = 4'd11,
        OP_ROL = 4'd12, OP_ROR = 4'd13, OP_MUL = 4'd14, OP_CMP = 4'd15
    } op_e;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: N-step unsigned shift-add multiplier; o_done/o_product present the final step combinationally
module alu_mul_iter #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_start,
    input  logic [N-1:0]   i_a,
    input  logic [N-1:0]   i_b,
    output logic           o_busy,
    output logic           o_done,
    output logic [2*N-1:0] o_product
);
    localparam int CNT_W = $clog2(N + 1);
    logic [CNT_W-1:0] r_cnt;
    logic [N-1:0]     r_mcand;
    logic [2*N-1:0]   r_p;
    logic [N:0]       w_sum;
    // upper half accumulates, lower half holds the remaining multiplier bits
    assign w_sum     = {1'b0, r_p[2*N-1:N]} + {1'b0, r_mcand & {N{r_p[0]}}};
    assign o_product = {w_sum, r_p[N-1:1]};
    assign o_busy    = r_cnt != '0;
    assign o_done    = r_cnt == CNT_W'(1);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_mcand <= '0;
            r_p     <= '0;
        end else if (i_start) begin
            r_cnt   <= CNT_W'(N);
            r_mcand <= i_a;
            r_p     <= {{N{1'b0}}, i_b};
        end else if (o_busy) begin
            r_cnt   <= r_cnt - 1'b1;
            r_p     <= o_product;
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered N-bit ALU with valid/ready handshake, status flags and an iterative multiplier
module alu_seq
    import alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [MODE_W-1:0] mode,
    input  logic [N-1:0]      in_a,
    input  logic [N-1:0]      in_b,
    output logic [N-1:0]      out,
    output logic [N-1:0]      out_hi,
    output logic              out_valid,
    output logic              flag_zero,
    output logic              flag_carry,
    output logic              flag_neg,
    output logic              flag_ovf,
    output logic              flag_illegal
);
    state_e         r_state;
    logic [N-1:0]   r_out, r_out_hi;
    logic           r_valid, r_zero, r_carry, r_neg, r_ovf, r_illegal;
    op_e            w_op;
    logic [N-1:0]   w_addend, w_subtr, w_res;
    logic [N:0]     w_sum, w_diff;
    logic           w_c, w_v, w_illegal, w_mul_start, w_mul_busy, w_mul_done;
    logic [2*N-1:0] w_prod;
    assign w_op        = op_e'(mode);
    assign in_ready    = (r_state == ST_IDLE) && !w_mul_busy;
    assign w_mul_start = in_ready && in_valid && (w_op == OP_MUL);
    assign {out, out_hi, out_valid} = {r_out, r_out_hi, r_valid};
    assign {flag_zero, flag_carry, flag_neg, flag_ovf, flag_illegal} = {r_zero, r_carry, r_neg, r_ovf, r_illegal};
    // carry/borrow in comes from the flag stored before this op
    assign w_addend = (w_op == OP_INC) ? N'(1) : in_b;
    assign w_subtr  = (w_op == OP_DEC) ? N'(1) : in_b;
    assign w_sum    = {1'b0, in_a} + {1'b0, w_addend} + {{N{1'b0}}, (w_op == OP_ADC) && r_carry};
    assign w_diff   = {1'b0, in_a} - {1'b0, w_subtr} - {{N{1'b0}}, (w_op == OP_SBB) && r_carry};
    always_comb begin
        w_res     = '0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        w_illegal = 1'b0;
        case (w_op)
            OP_ADD, OP_ADC, OP_INC: begin
                {w_c, w_res} = w_sum;
                w_v = (in_a[N-1] == w_addend[N-1]) && (w_sum[N-1] != in_a[N-1]);
            end
            OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
                {w_c, w_res} = w_diff;
                w_v = (in_a[N-1] != w_subtr[N-1]) && (w_diff[N-1] != in_a[N-1]);
            end
            OP_AND: w_res = in_a & in_b;
            OP_OR:  w_res = in_a | in_b;
            OP_XOR: w_res = in_a ^ in_b;
            OP_NOT: w_res = ~in_a;
            OP_SHL: {w_c, w_res} = {in_a, 1'b0};
            OP_SHR: {w_res, w_c} = {1'b0, in_a};
            OP_ROL: {w_c, w_res} = {in_a, in_a[N-1]};
            OP_ROR: {w_res, w_c} = {in_a[0], in_a};
            default: w_illegal = w_op != OP_MUL;
        endcase
    end
    alu_mul_iter #(.N(N)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_start   (w_mul_start),
        .i_a       (in_a),
        .i_b       (in_b),
        .o_busy    (w_mul_busy),
        .o_done    (w_mul_done),
        .o_product (w_prod)
    );
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_out     <= '0;
            r_out_hi  <= '0;
            r_valid   <= 1'b0;
            r_zero    <= 1'b0;
            r_carry   <= 1'b0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    if (w_op == OP_MUL) begin
                        r_state <= ST_BUSY;
                    end else begin
                        r_state   <= ST_DONE;
                        r_valid   <= 1'b1;
                        r_out_hi  <= '0;
                        r_illegal <= w_illegal;
                        if (w_illegal) begin
                            r_out <= '0;
                        end else begin
                            if (w_op != OP_CMP) r_out <= w_res;
                            r_zero  <= w_res == '0;
                            r_neg   <= w_res[N-1];
                            r_carry <= w_c;
                            r_ovf   <= w_v;
                        end
                    end
                end
                ST_BUSY: if (w_mul_done) begin
                    r_state   <= ST_DONE;
                    r_valid   <= 1'b1;
                    r_illegal <= 1'b0;
                    r_out     <= w_prod[N-1:0];
                    r_out_hi  <= w_prod[2*N-1:N];
                    r_zero    <= w_prod == '0;
                    r_neg     <= w_prod[N-1];
                    r_carry   <= |w_prod[2*N-1:N];
                    r_ovf     <= |w_prod[2*N-1:N];
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_illegal <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and randomized checks of alu_seq against an integer-arithmetic reference model
module tb_alu_seq;
    import alu_pkg::*;
    localparam int N = 8;
    logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
    logic [3:0]   mode = '0;
    logic [N-1:0] in_a = '0, in_b = '0;
    logic         in_ready, out_valid;
    logic [N-1:0] out, out_hi;
    logic         flag_zero, flag_carry, flag_neg, flag_ovf, flag_illegal;
    int checks = 0, failures = 0, cur_op = 0;
    int m_out = 0, m_hi = 0, m_z = 0, m_c = 0, m_n = 0, m_v = 0;

    always #5 clk = ~clk;

    alu_seq #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .in_a(in_a), .in_b(in_b), .out(out), .out_hi(out_hi),
        .out_valid(out_valid), .flag_zero(flag_zero), .flag_carry(flag_carry),
        .flag_neg(flag_neg), .flag_ovf(flag_ovf), .flag_illegal(flag_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s op=%0d observed=%0h expected=%0h", tag, cur_op, obs, exp);
        end
    endtask

    // reference: plain integer arithmetic on unsigned values and their signed readings
    task automatic model(input int op, input int a, input int b);
        int sa, sb, t, r, res, p;
        if (op == OP_INC || op == OP_DEC) b = 1;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        res = 0;
        if (op == OP_MUL) begin
            p = a * b;
            m_out = p % 256; m_hi = p / 256;
            m_z = (p == 0); m_c = (m_hi != 0); m_v = m_c; m_n = (m_out >= 128);
            return;
        end
        case (op)
            OP_ADD, OP_ADC, OP_INC: begin
                t = (op == OP_ADC) ? m_c : 0;
                r = a + b + t;
                res = r % 256; m_c = (r > 255);
                m_v = (sa + sb + t > 127) || (sa + sb + t < -128);
            end
            OP_SUB, OP_SBB, OP_DEC, OP_CMP: begin
                t = (op == OP_SBB) ? m_c : 0;
                r = a - b - t;
                res = (r + 512) % 256; m_c = (r < 0);
                m_v = (sa - sb - t > 127) || (sa - sb - t < -128);
            end
            default: begin
                case (op)
                    OP_AND: res = a & b;
                    OP_OR:  res = a | b;
                    OP_XOR: res = a ^ b;
                    OP_NOT: res = 255 - a;
                    OP_SHL: begin res = (a * 2) % 256; m_c = a / 128; end
                    OP_SHR: begin res = a / 2; m_c = a % 2; end
                    OP_ROL: begin res = (a * 2) % 256 + a / 128; m_c = a / 128; end
                    default: begin res = a / 2 + (a % 2) * 128; m_c = a % 2; end
                endcase
                if (op <= OP_NOT) m_c = 0;
                m_v = 0;
            end
        endcase
        if (op != OP_CMP) m_out = res;
        m_hi = 0; m_z = (res == 0); m_n = (res >= 128);
    endtask

    task automatic check_all();
        check("out", out, m_out);
        check("out_hi", out_hi, m_hi);
        check("zero", flag_zero, m_z);
        check("carry", flag_carry, m_c);
        check("neg", flag_neg, m_n);
        check("ovf", flag_ovf, m_v);
        check("illegal", flag_illegal, 0);
    endtask

    task automatic check_reset();
        check("rst_ready", in_ready, 1);
        check("rst_valid", out_valid, 0);
        m_out = 0; m_hi = 0; m_z = 0; m_c = 0; m_n = 0; m_v = 0;
        check_all();
    endtask

    task automatic do_op(input int op, input int a, input int b, input bit hold);
        int lat;
        @(negedge clk);
        cur_op = op;
        check("ready_idle", in_ready, 1);
        mode = 4'(op); in_a = N'(a); in_b = N'(b); in_valid = 1'b1;
        model(op, a, b);
        @(posedge clk);
        #1;
        in_a = N'($urandom); in_b = N'($urandom); mode = 4'($urandom);
        in_valid = hold;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            check("ready_busy", in_ready, 0);
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check("latency", lat, (op == OP_MUL) ? N + 1 : 1);
        check_all();
        @(negedge clk);
        check("valid_pulse", out_valid, 0);
    endtask

    initial begin
        int a, b;
        repeat (2) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        do_op(OP_ADD, 8'hFF, 8'h01, 1'b0);
        check("add_wrap", {flag_carry, flag_zero, out}, 10'h300);
        do_op(OP_ADC, 8'h00, 8'h00, 1'b0);
        check("adc_cin", out, 8'h01);

        // abort a multiply in flight
        @(negedge clk);
        cur_op = OP_MUL;
        mode = 4'(OP_MUL); in_a = 8'h12; in_b = 8'h34; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("mul_busy", in_ready, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset();
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check("abort_no_valid", out_valid, 0);
        end

        do_op(OP_SUB, 8'h80, 8'h01, 1'b0);
        check("sub_ovf", {flag_ovf, flag_carry, flag_neg, out}, 11'h47F);
        do_op(OP_CMP, 8'h05, 8'h05, 1'b0);
        check("cmp_keep", {flag_zero, out}, 9'h17F);
        do_op(OP_MUL, 8'hFF, 8'hFF, 1'b1);
        check("mul_ff", {out_hi, out}, 16'hFE01);
        do_op(OP_ROL, 8'h81, 8'h00, 1'b0);
        check("rol", {flag_carry, out}, 9'h103);
        do_op(OP_SHR, 8'h01, 8'h00, 1'b0);
        check("shr", {flag_zero, flag_carry, out}, 10'h300);
        do_op(OP_DEC, 8'h00, 8'h00, 1'b0);
        check("dec0", {flag_carry, out}, 9'h1FF);
        do_op(OP_MUL, 8'h00, 8'h9C, 1'b0);
        do_op(OP_SBB, 8'h00, 8'h7F, 1'b0);

        for (int i = 0; i < 60; i++)
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                  int'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

        // back-to-back issue with in_valid held high
        @(negedge clk);
        cur_op = OP_XOR;
        mode = 4'(OP_XOR);
        in_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                a = int'($urandom_range(0, 255));
                b = int'($urandom_range(0, 255));
                in_a = N'(a); in_b = N'(b);
                model(OP_XOR, a, b);
            end
            @(negedge clk);
            check("b2b_valid", out_valid, (i % 2 == 0) ? 1 : 0);
            check("b2b_ready", in_ready, (i % 2 == 0) ? 0 : 1);
            if (i % 2 == 0) begin
                check_all();
                in_a = N'($urandom); in_b = N'($urandom);
            end
        end
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered ALU for the datapath. Generalises the 8-bit single-cycle ALU to width N.
- Adds a valid/ready handshake, signed-overflow and negative flags, shift/rotate ops, CMP, and a multi-cycle unsigned shift-add multiplier with a 2N-bit result.
- Sits between the register file/accumulator and the bus. The controller issues one op and waits for out_valid.

Parameters:
- N, 8, operand/result width (N >= 2)
- CNT_W, $clog2(N+1), width of the multiply iteration counter (derived, not overridden)

Ports:
- clk  input  1  system clock, all state changes on posedge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  op request; accepted on a posedge where in_valid && in_ready
- in_ready  output  1  high when idle and able to accept an op
- mode  input  4  opcode, encodings in shared package
- in_a  input  N  operand A
- in_b  input  N  operand B (ignored by INC, DEC, NOT, shift/rotate ops)
- out  output  N  result low half
- out_hi  output  N  MUL high half; 0 for all other ops
- out_valid  output  1  one-cycle pulse when out/out_hi/flags are updated
- flag_zero, flag_carry, flag_neg, flag_ovf  output  1 each  status flags
- flag_illegal  output  1  high for the out_valid cycle of an undefined opcode

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, in_ready=1, out=0, out_hi=0, out_valid=0, all flags=0, counter=0. Reset takes priority and aborts an in-progress MUL with no out_valid.
- FSM states: IDLE, BUSY (MUL only), DONE.
  - IDLE: accept -> single-cycle op computes and registers its result, goes to DONE; MUL latches operands, clears the accumulator and goes to BUSY.
  - BUSY: runs N iterations, one per cycle (if multiplier LSB then acc += multiplicand; shift), then goes to DONE.
  - DONE: out_valid=1 for exactly 1 cycle, then back to IDLE.
- in_ready=1 only in IDLE. in_valid is ignored in BUSY/DONE. Operands and mode are sampled only at accept; later changes have no effect.
- Latency from the accept edge t: single-cycle ops have out_valid high in cycle t+1. MUL has out_valid high in cycle t+N+1. Back-to-back issue rate: 1 op per 2 cycles.
- out, out_hi and flags hold their values between ops.
- Arithmetic uses an (N+1)-bit internal sum.
  - ADD: a+b.
  - ADC: a+b+flag_carry, using the stored carry at accept.
  - SUB: a-b; carry=1 means borrow (a<b unsigned).
  - SBB: a-b-flag_carry.
  - INC: a+1. DEC: a-1.
  - CMP: a-b, updates flags only; out is unchanged.
- Signed overflow:
  - add ops: ovf = (a[N-1]==b'[N-1]) && (res[N-1]!=a[N-1]), where b' is the effective addend (1 for INC).
  - sub ops: ovf = (a[N-1]!=b[N-1]) && (res[N-1]!=a[N-1]).
- AND, OR, XOR, NOT(a): carry=0, ovf=0.
- SHL, SHR (logical), ROL, ROR: shift by 1. Carry = bit shifted/rotated out. ovf=0.
- MUL: unsigned, {out_hi,out}=a*b. Carry=ovf=(out_hi!=0). Zero tests the full 2N bits. Neg=out[N-1].
- Flag rules for all ops: zero=(result==0), neg=result[N-1]. CMP evaluates these on the internal difference.
- Illegal opcode: out=0, out_hi=0, flags unchanged, flag_illegal=1 with out_valid. flag_illegal=0 otherwise.
- Edge cases:
  - ADD of 0xFF+0x01 wraps to 0 with carry=1, zero=1.
  - DEC of 0 gives 0xFF with carry=1.
  - MUL by 0 still takes N cycles.

Decomposition:
- Shared package alu_pkg holds: opcode constants (ADD=0, ADC=1, SUB=2, SBB=3, INC=4, DEC=5, AND=6, OR=7, XOR=8, NOT=9, SHL=10, SHR=11, ROL=12, ROR=13, MUL=14, CMP=15), FSM state encodings, and the mode width constant (4).
- One sub-module, alu_mul_iter: an N-step shift-add multiplier with start, busy, done handshake and a 2N-bit product.
- The top level holds the FSM, the combinational single-cycle datapath and the flag logic.

Test Plan (N=8):
- Reset with rst_n=0 during a MUL in BUSY -> next cycle in_ready=1, out=0, all flags=0, and no out_valid pulse.
- ADD a=0xFF, b=0x01 -> cycle t+1: out=0x00, carry=1, zero=1, ovf=0. Then ADC a=0x00, b=0x00 -> out=0x01, carry=0.
- SUB a=0x80, b=0x01 -> out=0x7F, ovf=1, carry=0, neg=0. Then CMP a=0x05, b=0x05 -> zero=1, out still 0x7F.
- MUL a=0xFF, b=0xFF -> out_valid exactly at t+9 with {out_hi,out}=0xFE01 and carry=ovf=1. in_valid held high during BUSY is ignored and in_ready stays 0.
- ROL a=0x81 -> out=0x03, carry=1. SHR a=0x01 -> out=0x00, carry=1, zero=1.
- Back-to-back issue with in_valid held high -> accepts every 2 cycles and out_valid pulses every 2 cycles. Operand changes after accept do not alter the result.
